// File: rtl/cf_fft_bfly_pipe.sv
// Four-stage radix-2 DIT butterfly: X = A + B*W, Y = A - B*W, with valid tracking and sticky overflow.
// Define CF_FFT_BFLY_SAT_EN to saturate (instead of wrap) the final width reduction.
module cf_fft_bfly_pipe #(
    parameter int DW = 8,
    parameter int TW = 8
) (
    input  logic              clock_c,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              in_valid,
    input  logic [2*DW-1:0]   in_a,
    input  logic [2*DW-1:0]   in_b,
    input  logic [2*TW-1:0]   in_w,
    input  logic              in_scale,
    input  logic              ovf_clr,
    output logic              out_valid,
    output logic [2*DW-1:0]   out_x,
    output logic [2*DW-1:0]   out_y,
    output logic              ovf_flag
);
    localparam int PW = DW + TW;
    localparam int SW = DW + 3;
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [2*DW-1:0]         a1_q, b1_q, a2_q, a3_q;
    logic [2*TW-1:0]         w1_q;
    logic                    sc1_q, sc2_q, sc3_q;
    logic                    v1_q, v2_q, v3_q;
    logic signed [DW:0]      prr_q, pii_q, pri_q, pir_q;
    logic signed [DW:0]      prr_d, pii_d, pri_d, pir_d;
    logic signed [DW+1:0]    tre_q, tim_q, tre_d, tim_d;
    logic [2*DW-1:0]         x_q, y_q, x_d, y_d;
    logic                    vo_q;
    logic                    ovf_q, ovf_d, ovf_hit;

    logic signed [DW-1:0]    br, bi;
    logic signed [TW-1:0]    wr, wi;
    logic signed [PW-1:0]    m_rr, m_ii, m_ri, m_ir;
    logic signed [SW-1:0]    a_re, a_im, t_re, t_im;
    logic signed [SW-1:0]    s_xr, s_xi, s_yr, s_yi;

    function automatic logic fits(input logic signed [SW-1:0] v);
        logic [SW-DW:0] top;
        top = v[SW-1:DW-1];
        return (&top) | ~(|top);
    endfunction

    function automatic logic [DW-1:0] reduce_w(input logic signed [SW-1:0] v);
`ifdef CF_FFT_BFLY_SAT_EN
        if (fits(v)) return v[DW-1:0];
        return v[SW-1] ? SAT_MIN : SAT_MAX;
`else
        return v[DW-1:0];
`endif
    endfunction

    // Products keep DW+1 bits after the Q1.(TW-1) rescale so (-1)*(-1.0) still fits.
    always_comb begin
        br    = $signed(b1_q[2*DW-1:DW]);
        bi    = $signed(b1_q[DW-1:0]);
        wr    = $signed(w1_q[2*TW-1:TW]);
        wi    = $signed(w1_q[TW-1:0]);
        m_rr  = br * wr;
        m_ii  = bi * wi;
        m_ri  = br * wi;
        m_ir  = bi * wr;
        prr_d = (DW+1)'(m_rr >>> (TW-1));
        pii_d = (DW+1)'(m_ii >>> (TW-1));
        pri_d = (DW+1)'(m_ri >>> (TW-1));
        pir_d = (DW+1)'(m_ir >>> (TW-1));
    end

    always_comb begin
        tre_d = $signed({prr_q[DW], prr_q}) - $signed({pii_q[DW], pii_q});
        tim_d = $signed({pri_q[DW], pri_q}) + $signed({pir_q[DW], pir_q});
    end

    always_comb begin
        a_re = $signed({{(SW-DW){a3_q[2*DW-1]}}, a3_q[2*DW-1:DW]});
        a_im = $signed({{(SW-DW){a3_q[DW-1]}}, a3_q[DW-1:0]});
        t_re = $signed({tre_q[DW+1], tre_q});
        t_im = $signed({tim_q[DW+1], tim_q});
        s_xr = a_re + t_re;
        s_xi = a_im + t_im;
        s_yr = a_re - t_re;
        s_yi = a_im - t_im;
        if (sc3_q) begin
            s_xr = s_xr >>> 1;
            s_xi = s_xi >>> 1;
            s_yr = s_yr >>> 1;
            s_yi = s_yi >>> 1;
        end
        x_d     = {reduce_w(s_xr), reduce_w(s_xi)};
        y_d     = {reduce_w(s_yr), reduce_w(s_yi)};
        ovf_hit = v3_q & ~(fits(s_xr) & fits(s_xi) & fits(s_yr) & fits(s_yi));
        // A fresh overflow beats a simultaneous clear.
        if (ce && ovf_hit)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            a1_q  <= '0; b1_q  <= '0; w1_q  <= '0; sc1_q <= 1'b0; v1_q <= 1'b0;
            prr_q <= '0; pii_q <= '0; pri_q <= '0; pir_q <= '0;
            a2_q  <= '0; sc2_q <= 1'b0; v2_q <= 1'b0;
            tre_q <= '0; tim_q <= '0; a3_q <= '0; sc3_q <= 1'b0; v3_q <= 1'b0;
            x_q   <= '0; y_q   <= '0; vo_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (ce) begin
                a1_q  <= in_a;  b1_q  <= in_b;  w1_q <= in_w;
                sc1_q <= in_scale;  v1_q <= in_valid;
                prr_q <= prr_d; pii_q <= pii_d; pri_q <= pri_d; pir_q <= pir_d;
                a2_q  <= a1_q;  sc2_q <= sc1_q; v2_q <= v1_q;
                tre_q <= tre_d; tim_q <= tim_d;
                a3_q  <= a2_q;  sc3_q <= sc2_q; v3_q <= v2_q;
                x_q   <= x_d;   y_q   <= y_d;   vo_q <= v3_q;
            end
        end
    end

    assign out_valid = vo_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign ovf_flag  = ovf_q;
endmodule

// File: tb/tb_cf_fft_bfly_pipe.sv
// Directed bench for cf_fft_bfly_pipe (DW=TW=8); expected values are hand-computed constants.
module tb_cf_fft_bfly_pipe;
    logic        clock_c, reset_n, ce, in_valid, in_scale, ovf_clr;
    logic [15:0] in_a, in_b, in_w;
    logic        out_valid, ovf_flag;
    logic [15:0] out_x, out_y;

    int tests_run    = 0;
    int tests_failed = 0;

    cf_fft_bfly_pipe #(.DW(8), .TW(8)) dut (
        .clock_c  (clock_c),
        .reset_n  (reset_n),
        .ce       (ce),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_w     (in_w),
        .in_scale (in_scale),
        .ovf_clr  (ovf_clr),
        .out_valid(out_valid),
        .out_x    (out_x),
        .out_y    (out_y),
        .ovf_flag (ovf_flag)
    );

    initial clock_c = 1'b0;
    always #5 clock_c = ~clock_c;

    task automatic tick();
        @(posedge clock_c);
        #1;
    endtask

    task automatic drive(input int are, input int aim, input int bre, input int bim,
                         input int wre, input int wim, input logic sc, input logic v);
        in_a     = {8'(are), 8'(aim)};
        in_b     = {8'(bre), 8'(bim)};
        in_w     = {8'(wre), 8'(wim)};
        in_scale = sc;
        in_valid = v;
    endtask

    // Issues the currently driven sample and counts enabled edges until out_valid (bounded).
    task automatic run_one(output int lat);
        tick();
        lat = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({out_valid, out_x, out_y, ovf_flag} !== 34'd0) begin
            $display("FAIL reset_hold: got v=%b x=%h y=%h ovf=%b, want all 0", out_valid, out_x, out_y, ovf_flag);
            tests_failed++;
        end
        #3 reset_n = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        tests_run++;
        if (out_valid !== 1'b0 || ovf_flag !== 1'b0) begin
            $display("FAIL reset_idle: got v=%b ovf=%b, want 0 0", out_valid, ovf_flag);
            tests_failed++;
        end
    endtask

    task automatic test_unity();
        int lat;
        drive(10, -5, 20, 10, 8'h7F, 0, 1'b0, 1'b1);
        run_one(lat);
        tests_run++;
        if (lat !== 4) begin
            $display("FAIL unity_latency: got %0d, want 4", lat);
            tests_failed++;
        end
        tests_run++;
        if (out_x !== {8'(29), 8'(4)} || out_y !== {8'(-9), 8'(-14)}) begin
            $display("FAIL unity_result: got x=%h y=%h, want x=1d04 y=f7f2", out_x, out_y);
            tests_failed++;
        end
        tests_run++;
        if (ovf_flag !== 1'b0) begin
            $display("FAIL unity_ovf: got %b, want 0", ovf_flag);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            $display("FAIL unity_single: got out_valid=%b one clock later, want 0", out_valid);
            tests_failed++;
        end
    endtask

    task automatic test_neg_j();
        int lat;
        drive(0, 0, 20, 10, 0, 8'h80, 1'b0, 1'b1);
        run_one(lat);
        tests_run++;
        if (lat !== 4 || out_x !== {8'(10), 8'(-20)} || out_y !== {8'(-10), 8'(20)}) begin
            $display("FAIL neg_j: got lat=%0d x=%h y=%h, want lat=4 x=0aec y=f614", lat, out_x, out_y);
            tests_failed++;
        end
    endtask

    task automatic test_scale();
        int lat;
        drive(100, 0, 100, 0, 8'h7F, 0, 1'b1, 1'b1);
        run_one(lat);
        tests_run++;
        if (lat !== 4 || out_x !== {8'(99), 8'(0)} || out_y !== {8'(0), 8'(0)}) begin
            $display("FAIL scale: got lat=%0d x=%h y=%h, want lat=4 x=6300 y=0000", lat, out_x, out_y);
            tests_failed++;
        end
        tests_run++;
        if (ovf_flag !== 1'b0) begin
            $display("FAIL scale_ovf: got %b, want 0", ovf_flag);
            tests_failed++;
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [15:0] exp_x;
`ifdef CF_FFT_BFLY_SAT_EN
        exp_x = {8'd127, 8'd0};
`else
        exp_x = {8'hC7, 8'd0};
`endif
        drive(100, 0, 100, 0, 8'h7F, 0, 1'b0, 1'b1);
        run_one(lat);
        tests_run++;
        if (lat !== 4 || out_x !== exp_x || out_y !== {8'(1), 8'(0)}) begin
            $display("FAIL ovf_result: got lat=%0d x=%h y=%h, want lat=4 x=%h y=0100", lat, out_x, out_y, exp_x);
            tests_failed++;
        end
        tests_run++;
        if (ovf_flag !== 1'b1) begin
            $display("FAIL ovf_set: got %b, want 1", ovf_flag);
            tests_failed++;
        end
        tick(); tick(); tick();
        tests_run++;
        if (ovf_flag !== 1'b1) begin
            $display("FAIL ovf_sticky: got %b, want 1", ovf_flag);
            tests_failed++;
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests_run++;
        if (ovf_flag !== 1'b0) begin
            $display("FAIL ovf_clear: got %b, want 0", ovf_flag);
            tests_failed++;
        end
        // Overflowing data carried by bubbles must not set the flag.
        drive(100, 0, 100, 0, 8'h7F, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (ovf_flag !== 1'b0) begin
            $display("FAIL ovf_bubble: got %b, want 0", ovf_flag);
            tests_failed++;
        end
    endtask

    task automatic test_clr_vs_set();
        drive(100, 0, 100, 0, 8'h7F, 0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || ovf_flag !== 1'b1) begin
            $display("FAIL clr_vs_set: got v=%b ovf=%b, want 1 1", out_valid, ovf_flag);
            tests_failed++;
        end
        ce = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests_run++;
        if (ovf_flag !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL clr_while_stalled: got ovf=%b v=%b, want ovf=0 v=1", ovf_flag, out_valid);
            tests_failed++;
        end
        ce = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [3];
        logic [31:0] got_r [3];
        logic [32:0] snap;
        int n;
        exp_r[0] = {8'(12), 8'(-3), 8'(10), 8'(-3)};
        exp_r[1] = {8'(25), 8'(-5), 8'(19), 8'(-7)};
        exp_r[2] = {8'(38), 8'(-7), 8'(28), 8'(-11)};
        drive(11, -3, 2, 1, 8'h7F, 0, 1'b0, 1'b1);
        tick();
        drive(22, -6, 4, 2, 8'h7F, 0, 1'b0, 1'b1);
        tick();
        ce = 1'b0;
        drive(-100, 50, 99, -99, 8'h80, 8'h80, 1'b1, 1'b1);
        snap = {out_valid, out_x, out_y};
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({out_valid, out_x, out_y} !== snap) begin
                $display("FAIL stall_freeze[%0d]: got %h, want %h", i, {out_valid, out_x, out_y}, snap);
                tests_failed++;
            end
        end
        ce = 1'b1;
        drive(33, -9, 6, 3, 8'h7F, 0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                if (n < 3) got_r[n] = {out_x, out_y};
                n++;
            end
            tick();
        end
        tests_run++;
        if (n !== 3) begin
            $display("FAIL b2b_count: got %0d results, want 3", n);
            tests_failed++;
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (k >= n || got_r[k] !== exp_r[k]) begin
                $display("FAIL b2b_result[%0d]: got %h (of %0d), want %h", k, got_r[k], n, exp_r[k]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        drive(100, 0, 100, 0, 8'h7F, 0, 1'b0, 1'b1);
        tick();
        drive(10, -5, 20, 10, 8'h7F, 0, 1'b0, 1'b1);
        tick(); tick(); tick();
        tests_run++;
        if (out_valid !== 1'b1 || ovf_flag !== 1'b1) begin
            $display("FAIL areset_pre: got v=%b ovf=%b, want 1 1", out_valid, ovf_flag);
            tests_failed++;
        end
        #3 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_x, out_y, ovf_flag} !== 34'd0) begin
            $display("FAIL areset_now: got v=%b x=%h y=%h ovf=%b, want all 0", out_valid, out_x, out_y, ovf_flag);
            tests_failed++;
        end
        in_valid = 1'b0;
        #2 reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) n++;
        end
        tests_run++;
        if (n !== 0 || ovf_flag !== 1'b0) begin
            $display("FAIL areset_stale: got %0d results ovf=%b, want 0 0", n, ovf_flag);
            tests_failed++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        ovf_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        #9;
        test_reset();
        test_unity();
        test_neg_j();
        test_scale();
        test_overflow();
        test_clr_vs_set();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
